// File: rtl/prbs_ber_checker.sv
// PRBS bit-error-rate checker for one QPSK rail: sweeps reference latency, locks to the best one, then counts errors.
// Optional BER_RESYNC_EN: re-sweep when a counted window exceeds PRBS_MAX_CYCLES/4 errors; adds o_resync_cnt.
module prbs_ber_checker #(
  parameter int unsigned PRBS_MAX_CYCLES = 511,
  parameter int unsigned START_SYN       = 511*690,
  parameter int unsigned START_CNT       = START_SYN + 511*511,
  parameter int unsigned NBT_CNT         = 64
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic                               i_enable,
  input  logic                               i_ref_bit,
  input  logic                               i_rx_bit,
  output logic [$clog2(PRBS_MAX_CYCLES)-1:0] o_latency,
  output logic                               o_locked,
  output logic [NBT_CNT-1:0]                 o_err_cnt,
  output logic [NBT_CNT-1:0]                 o_tot_cnt,
  output logic                               o_err_led
`ifdef BER_RESYNC_EN
  ,
  output logic [15:0]                        o_resync_cnt
`endif
);
  localparam int unsigned LW = $clog2(PRBS_MAX_CYCLES);
  localparam int unsigned EW = $clog2(PRBS_MAX_CYCLES + 1);
  localparam logic [LW-1:0] LAST = LW'(PRBS_MAX_CYCLES - 1);
  localparam bit SKIP_SYNC = (START_CNT <= START_SYN);

  typedef enum logic [1:0] {IDLE, SYNC, COUNT} state_t;
  state_t state;

  logic [PRBS_MAX_CYCLES-2:0] dly;
  logic [PRBS_MAX_CYCLES-1:0] taps;
  logic [31:0]                sym_cnt;
  logic [LW-1:0]              sw_w, sw_lat, best_lat, win_w;
  logic [EW-1:0]              sw_err, best_err, win_err;
  logic [EW-1:0]              sw_err_nxt, win_err_nxt;
  logic                       sw_done, sw_miss, cnt_miss;
  logic                       at_syn, at_cnt, tot_full, lock_now, sw_step;
`ifdef BER_RESYNC_EN
  logic                       resync;
`endif

  // taps[L] is the reference bit from L enables ago; taps[0] is the live input.
  assign taps        = {dly, i_ref_bit};
  assign sw_miss     = i_rx_bit ^ taps[sw_lat];
  assign cnt_miss    = i_rx_bit ^ taps[o_latency];
  assign sw_err_nxt  = sw_err + EW'(sw_miss);
  assign win_err_nxt = win_err + EW'(cnt_miss);
  assign at_syn      = (sym_cnt == START_SYN);
  assign at_cnt      = (sym_cnt == START_CNT);
  assign tot_full    = &o_tot_cnt;

`ifdef BER_RESYNC_EN
  assign lock_now = (state == SYNC) && (resync ? sw_done : at_cnt);
`else
  assign lock_now = (state == SYNC) && at_cnt;
`endif

  // The entry enable already evaluates window 0 of candidate 0, so the sweep ends exactly at START_CNT-1.
  always_comb begin
    sw_step = 1'b0;
    case (state)
      IDLE:    sw_step = at_syn && !SKIP_SYNC;
      SYNC:    sw_step = !lock_now && !sw_done;
      default: sw_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      dly       <= '0;
      sym_cnt   <= '0;
      sw_w      <= '0;
      sw_lat    <= '0;
      sw_err    <= '0;
      sw_done   <= 1'b0;
      best_err  <= '1;
      best_lat  <= '0;
      win_w     <= '0;
      win_err   <= '0;
      o_latency <= '0;
      o_locked  <= 1'b0;
      o_err_cnt <= '0;
      o_tot_cnt <= '0;
      o_err_led <= 1'b0;
`ifdef BER_RESYNC_EN
      resync       <= 1'b0;
      o_resync_cnt <= '0;
`endif
    end else if (i_enable) begin
      dly <= {dly[PRBS_MAX_CYCLES-3:0], i_ref_bit};
      if (~&sym_cnt) sym_cnt <= sym_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (SKIP_SYNC && at_cnt) begin
            state     <= COUNT;
            o_locked  <= 1'b1;
            o_latency <= '0;
          end else if (!SKIP_SYNC && at_syn) begin
            state <= SYNC;
          end
        end
        SYNC: begin
          if (lock_now) begin
            state     <= COUNT;
            o_locked  <= 1'b1;
            o_latency <= best_lat;
`ifdef BER_RESYNC_EN
            resync    <= 1'b0;
`endif
          end
        end
        COUNT: begin
          if (!tot_full) begin
            o_tot_cnt <= o_tot_cnt + NBT_CNT'(1);
            if (cnt_miss && (~&o_err_cnt)) o_err_cnt <= o_err_cnt + NBT_CNT'(1);
            if (win_w == LAST) begin
              win_w     <= '0;
              win_err   <= '0;
              o_err_led <= (win_err_nxt != '0);
`ifdef BER_RESYNC_EN
              if (win_err_nxt > EW'(PRBS_MAX_CYCLES / 4)) begin
                state    <= SYNC;
                o_locked <= 1'b0;
                resync   <= 1'b1;
                sw_w     <= '0;
                sw_lat   <= '0;
                sw_err   <= '0;
                sw_done  <= 1'b0;
                best_err <= '1;
                best_lat <= '0;
                if (~&o_resync_cnt) o_resync_cnt <= o_resync_cnt + 16'd1;
              end
`endif
            end else begin
              win_w   <= win_w + LW'(1);
              win_err <= win_err_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (sw_step) begin
        if (sw_w == LAST) begin
          sw_w   <= '0;
          sw_err <= '0;
          if (sw_err_nxt < best_err) begin
            best_err <= sw_err_nxt;
            best_lat <= sw_lat;
          end
          if (sw_lat == LAST) sw_done <= 1'b1;
          else                sw_lat  <= sw_lat + LW'(1);
        end else begin
          sw_w   <= sw_w + LW'(1);
          sw_err <= sw_err_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: PRBS5 reference with a 31-deep checker, array-based reference model.
module tb_prbs_ber_checker;
  localparam int P    = 31;
  localparam int SYN  = 10;
  localparam int CNT  = SYN + P*P;
  localparam int NBT  = 12;
  localparam int SAT  = (1 << NBT) - 1;
  localparam int MAXN = 8192;
  localparam int F    = CNT + 1;   // first counted enable index, main instance
  localparam int FS   = 4;         // first counted enable index, skip-sync instance (START_CNT=3)

  logic clk = 1'b0;
  logic i_reset, i_enable, i_ref_bit, i_rx_bit;
  logic [4:0] lat, lat_s;
  logic lock, lock_s, led, led_s;
  logic [NBT-1:0] err, tot, err_s, tot_s;
`ifdef BER_RESYNC_EN
  logic [15:0] rs_cnt, rs_cnt_s;
`endif

  always #5 clk = ~clk;

  prbs_ber_checker #(.PRBS_MAX_CYCLES(P), .START_SYN(SYN), .START_CNT(CNT), .NBT_CNT(NBT)) dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
    .o_latency(lat), .o_locked(lock), .o_err_cnt(err), .o_tot_cnt(tot), .o_err_led(led)
`ifdef BER_RESYNC_EN
    , .o_resync_cnt(rs_cnt)
`endif
  );

  prbs_ber_checker #(.PRBS_MAX_CYCLES(P), .START_SYN(5), .START_CNT(3), .NBT_CNT(NBT)) dut_s (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
    .o_latency(lat_s), .o_locked(lock_s), .o_err_cnt(err_s), .o_tot_cnt(tot_s), .o_err_led(led_s)
`ifdef BER_RESYNC_EN
    , .o_resync_cnt(rs_cnt_s)
`endif
  );

  bit ref_h [MAXN];
  bit rx_h  [MAXN];
  int n_en, cur_delay, flip_per;
  logic [4:0] lfsr;
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic bit mtap(int n, int l);
    return (n - l >= 0) ? ref_h[n - l] : 1'b0;
  endfunction

  function automatic int model_lat();
    int best = 1 << 30;
    int bl = 0;
    for (int l = 0; l < P; l++) begin
      int e = 0;
      for (int w = 0; w < P; w++) begin
        int n = SYN + l*P + w;
        if (rx_h[n] != mtap(n, l)) e++;
      end
      if (e < best) begin best = e; bl = l; end
    end
    return bl;
  endfunction

  function automatic int m_tot(int first);
    int t = n_en - first;
    if (t < 0) t = 0;
    if (t > SAT) t = SAT;
    return t;
  endfunction

  function automatic int m_err(int first, int l);
    int e = 0;
    for (int c = 0; c < m_tot(first); c++)
      if (rx_h[first + c] != mtap(first + c, l)) e++;
    return e;
  endfunction

  function automatic bit m_led(int first, int l);
    int k = m_tot(first) / P;
    if (k == 0) return 1'b0;
    for (int c = (k-1)*P; c < k*P; c++)
      if (rx_h[first + c] != mtap(first + c, l)) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit en);
    bit r, x;
    if (en) begin
      r = lfsr[4];
      lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      ref_h[n_en] = r;
      x = (n_en >= cur_delay) ? ref_h[n_en - cur_delay] : 1'b0;
      if (flip_per > 0 && n_en > CNT && ((n_en - CNT) % flip_per) == 0) x = ~x;
      rx_h[n_en] = x;
      n_en++;
    end else begin
      r = 1'($urandom_range(0, 1));
      x = 1'($urandom_range(0, 1));
    end
    i_enable = en; i_ref_bit = r; i_rx_bit = x;
    @(posedge clk); #1;
  endtask

  task automatic run_en(input int k);
    for (int i = 0; i < k; i++) step(1'b1);
  endtask

  task automatic start_run(input int d, input int fp);
    i_reset = 1'b0; i_enable = 1'b0; i_ref_bit = 1'b0; i_rx_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b1;
    n_en = 0; cur_delay = d; flip_per = fp;
    lfsr = 5'($urandom_range(1, 31));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (lock !== 1'b0)  begin errors++; $display("FAIL rst_locked got %0d exp 0", lock); end
    checks++; if (lat !== 5'd0)   begin errors++; $display("FAIL rst_latency got %0d exp 0", lat); end
    checks++; if (err !== '0)     begin errors++; $display("FAIL rst_err got %0d exp 0", err); end
    checks++; if (tot !== '0)     begin errors++; $display("FAIL rst_tot got %0d exp 0", tot); end
    checks++; if (led !== 1'b0)   begin errors++; $display("FAIL rst_led got %0d exp 0", led); end
    checks++; if (lock_s !== 1'b0) begin errors++; $display("FAIL rst_locked_s got %0d exp 0", lock_s); end
    start_run(3, 7);
    run_en(CNT + 80);
    #2 i_reset = 1'b0;
    #1;
    checks++; if (lock !== 1'b0)  begin errors++; $display("FAIL async_rst_locked got %0d exp 0", lock); end
    checks++; if (lat !== 5'd0)   begin errors++; $display("FAIL async_rst_latency got %0d exp 0", lat); end
    checks++; if (tot !== '0)     begin errors++; $display("FAIL async_rst_tot got %0d exp 0", tot); end
    checks++; if (err !== '0)     begin errors++; $display("FAIL async_rst_err got %0d exp 0", err); end
    checks++; if (tot_s !== '0)   begin errors++; $display("FAIL async_rst_tot_s got %0d exp 0", tot_s); end
  endtask

  task automatic test_delay_sweep();
    int d = $urandom_range(1, P-1);
    start_run(d, 0);
    run_en(3);
    checks++; if (lock_s !== 1'b0) begin errors++; $display("FAIL skip_prelock got %0d exp 0", lock_s); end
    run_en(1);
    checks++; if (lock_s !== 1'b1) begin errors++; $display("FAIL skip_lock got %0d exp 1", lock_s); end
    checks++; if (lat_s !== 5'd0)  begin errors++; $display("FAIL skip_latency got %0d exp 0", lat_s); end
    run_en(CNT - 4);
    checks++; if (lock !== 1'b0)   begin errors++; $display("FAIL sweep_prelock got %0d exp 0", lock); end
    run_en(1);
    checks++; if (lock !== 1'b1)   begin errors++; $display("FAIL sweep_lock got %0d exp 1", lock); end
    checks++; if (lat !== 5'(d))   begin errors++; $display("FAIL sweep_latency got %0d exp %0d", lat, d); end
    checks++; if (lat !== 5'(model_lat())) begin errors++; $display("FAIL sweep_latency_model got %0d exp %0d", lat, model_lat()); end
    checks++; if (tot !== '0)      begin errors++; $display("FAIL sweep_tot0 got %0d exp 0", tot); end
    run_en(100);
    checks++; if (tot !== NBT'(m_tot(F)))     begin errors++; $display("FAIL sweep_tot got %0d exp %0d", tot, m_tot(F)); end
    checks++; if (err !== NBT'(m_err(F, d)))  begin errors++; $display("FAIL sweep_err got %0d exp %0d", err, m_err(F, d)); end
    checks++; if (led !== m_led(F, d))        begin errors++; $display("FAIL sweep_led got %0d exp %0d", led, m_led(F, d)); end
    checks++; if (tot_s !== NBT'(m_tot(FS)))  begin errors++; $display("FAIL skip_tot got %0d exp %0d", tot_s, m_tot(FS)); end
    checks++; if (err_s !== NBT'(m_err(FS, 0))) begin errors++; $display("FAIL skip_err got %0d exp %0d", err_s, m_err(FS, 0)); end
  endtask

  task automatic test_delay_zero();
    start_run(0, 0);
    run_en(CNT + 1 + 70);
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL zero_lock got %0d exp 1", lock); end
    checks++; if (lat !== 5'd0)  begin errors++; $display("FAIL zero_latency got %0d exp 0", lat); end
    checks++; if (err !== '0)    begin errors++; $display("FAIL zero_err got %0d exp 0", err); end
    checks++; if (tot !== NBT'(m_tot(F))) begin errors++; $display("FAIL zero_tot got %0d exp %0d", tot, m_tot(F)); end
  endtask

  task automatic test_sparse_errors();
    start_run(5, 40);
    run_en(CNT + 1);
    for (int i = 0; i < 14; i++) begin
      run_en($urandom_range(1, 45));
      checks++; if (tot !== NBT'(m_tot(F)))    begin errors++; $display("FAIL sparse_tot got %0d exp %0d", tot, m_tot(F)); end
      checks++; if (err !== NBT'(m_err(F, 5))) begin errors++; $display("FAIL sparse_err got %0d exp %0d", err, m_err(F, 5)); end
      checks++; if (led !== m_led(F, 5))       begin errors++; $display("FAIL sparse_led got %0d exp %0d", led, m_led(F, 5)); end
    end
    checks++; if (err !== NBT'(m_tot(F) / 40)) begin errors++; $display("FAIL sparse_ratio got %0d exp %0d", err, m_tot(F) / 40); end
  endtask

  task automatic test_enable_gaps();
    start_run(12, 23);
    for (int s = 0; s < 3*(CNT + 90); s++) begin
      step(s % 3 == 0);
      if (s % 3 == 0 && n_en == CNT) begin
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL gap_prelock got %0d exp 0", lock); end
      end
      if (s % 3 == 0 && n_en == CNT + 1) begin
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL gap_lock got %0d exp 1", lock); end
        checks++; if (lat !== 5'd12) begin errors++; $display("FAIL gap_latency got %0d exp 12", lat); end
      end
      if (n_en > CNT + 1 && s % 5 == 0) begin
        checks++; if (tot !== NBT'(m_tot(F)))     begin errors++; $display("FAIL gap_tot got %0d exp %0d", tot, m_tot(F)); end
        checks++; if (err !== NBT'(m_err(F, 12))) begin errors++; $display("FAIL gap_err got %0d exp %0d", err, m_err(F, 12)); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int d2 = $urandom_range(1, P-1);
    start_run(9, 0);
    run_en(SYN + 100);
    i_reset = 1'b0; i_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL midrst_locked got %0d exp 0", lock); end
    checks++; if (lat !== 5'd0)  begin errors++; $display("FAIL midrst_latency got %0d exp 0", lat); end
    checks++; if (tot !== '0)    begin errors++; $display("FAIL midrst_tot got %0d exp 0", tot); end
    checks++; if (led !== 1'b0)  begin errors++; $display("FAIL midrst_led got %0d exp 0", led); end
    i_reset = 1'b1;
    n_en = 0; cur_delay = d2; flip_per = 0;
    run_en(CNT);
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL midrst_prelock got %0d exp 0", lock); end
    run_en(1);
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL midrst_lock got %0d exp 1", lock); end
    checks++; if (lat !== 5'(d2)) begin errors++; $display("FAIL midrst_latency_new got %0d exp %0d", lat, d2); end
  endtask

`ifdef BER_RESYNC_EN
  task automatic test_resync();
    int d1 = $urandom_range(1, 14);
    int d2 = d1 + $urandom_range(1, 15);
    bit fell = 1'b0;
    bit rose = 1'b0;
    start_run(d1, 0);
    run_en(CNT + 1 + 40);
    cur_delay = d2;
    for (int i = 0; i < 4*P && !fell; i++) begin
      step(1'b1);
      if (lock === 1'b0) fell = 1'b1;
    end
    checks++; if (fell !== 1'b1) begin errors++; $display("FAIL resync_drop got %0d exp 1", fell); end
    for (int i = 0; i < 2*P*P && !rose; i++) begin
      step(1'b1);
      if (lock === 1'b1) rose = 1'b1;
    end
    checks++; if (rose !== 1'b1) begin errors++; $display("FAIL resync_relock got %0d exp 1", rose); end
    checks++; if (lat !== 5'(d2)) begin errors++; $display("FAIL resync_latency got %0d exp %0d", lat, d2); end
    checks++; if (rs_cnt !== 16'd1) begin errors++; $display("FAIL resync_cnt got %0d exp 1", rs_cnt); end
  endtask
`endif

  task automatic test_saturation();
    int d = $urandom_range(0, P-1);
    start_run(d, 50);
    run_en(CNT + 1 + SAT - 1);
    checks++; if (tot !== NBT'(SAT - 1)) begin errors++; $display("FAIL sat_tot_m1 got %0d exp %0d", tot, SAT - 1); end
    run_en(1);
    checks++; if (tot !== NBT'(SAT))     begin errors++; $display("FAIL sat_tot got %0d exp %0d", tot, SAT); end
    run_en(120);
    checks++; if (tot !== NBT'(SAT))     begin errors++; $display("FAIL sat_tot_hold got %0d exp %0d", tot, SAT); end
    checks++; if (err !== NBT'(m_err(F, d))) begin errors++; $display("FAIL sat_err_hold got %0d exp %0d", err, m_err(F, d)); end
    checks++; if (led !== m_led(F, d))   begin errors++; $display("FAIL sat_led got %0d exp %0d", led, m_led(F, d)); end
    checks++; if (tot_s !== NBT'(SAT))   begin errors++; $display("FAIL sat_tot_s got %0d exp %0d", tot_s, SAT); end
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_ref_bit = 1'b0; i_rx_bit = 1'b0;
    n_en = 0; cur_delay = 0; flip_per = 0; lfsr = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_delay_sweep();
    test_delay_zero();
    test_sparse_errors();
    test_enable_gaps();
    test_reset_mid_sweep();
`ifdef BER_RESYNC_EN
    test_resync();
`endif
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
